// File: rtl/leds_pwm_out_if.sv
// Chip-select/strobe register bus between the CPU and the LED output peripheral.
interface leds_pwm_out_if;
  logic        chip_select_n;
  logic        write_n;
  logic        read_n;
  logic [1:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output chip_select_n, write_n, read_n, address, write_data,
    input  read_data
  );

  modport slave (
    input  chip_select_n, write_n, read_n, address, write_data,
    output read_data
  );
endinterface

// File: rtl/leds_pwm_out.sv
// Bus-written LED pattern with global PWM brightness and optional blink (macro LEDS_BLINK_EN).
// Registers: 0 DATA, 1 DUTY, 2 BLINK, 3 STATUS (read-only).
module leds_pwm_out #(
  parameter int unsigned NUM_LEDS   = 32,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned BLINK_BITS = 24
) (
  input  logic                iClk,
  input  logic                iReset_n,
  leds_pwm_out_if.slave       bus,
  output logic [NUM_LEDS-1:0] oLeds
);

  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrDuty   = 2'd1;
  localparam logic [1:0] AddrBlink  = 2'd2;
  localparam logic [1:0] AddrStatus = 2'd3;

  logic                wr_en, rd_en;
  logic [NUM_LEDS-1:0] data_q, data_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] duty_act_q, duty_act_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic [31:0]         read_data_q, read_data_d;
  logic [31:0]         blink_rd;
  logic                pwm_on;
  logic                phase;
  logic                unused_wdata;

  assign wr_en        = ~bus.chip_select_n & ~bus.write_n;
  assign rd_en        = ~bus.chip_select_n & ~bus.read_n;
  assign unused_wdata = ^bus.write_data;

`ifdef LEDS_BLINK_EN
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;

  always_comb begin
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (wr_en && bus.address == AddrBlink) begin
      // A new period restarts cleanly in the lit phase.
      blink_d     = bus.write_data[BLINK_BITS-1:0];
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_q == '0) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == blink_q - BLINK_BITS'(1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      blink_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign phase = phase_q;

  always_comb begin
    blink_rd                   = '0;
    blink_rd[BLINK_BITS-1:0]   = blink_q;
  end
`else
  assign phase    = 1'b1;
  assign blink_rd = '0;
`endif

  // duty_act only follows DUTY at the wrap so a period never mixes two duty values.
  assign pwm_on = (duty_act_q == '1) | (pwm_cnt_q < duty_act_q);

  always_comb begin
    data_d     = data_q;
    duty_d     = duty_q;
    pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
    duty_act_d = (pwm_cnt_q == '1) ? duty_q : duty_act_q;
    leds_d     = data_q & {NUM_LEDS{pwm_on & phase}};
    if (wr_en) begin
      case (bus.address)
        AddrData: data_d = bus.write_data[NUM_LEDS-1:0];
        AddrDuty: duty_d = bus.write_data[PWM_BITS-1:0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    read_data_d = read_data_q;
    if (rd_en) begin
      read_data_d = '0;
      case (bus.address)
        AddrData:   read_data_d[NUM_LEDS-1:0] = data_q;
        AddrDuty:   read_data_d[PWM_BITS-1:0] = duty_q;
        AddrBlink:  read_data_d               = blink_rd;
        AddrStatus: begin
          read_data_d[31]           = phase;
          read_data_d[PWM_BITS-1:0] = pwm_cnt_q;
        end
        default:    ;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      data_q      <= '0;
      duty_q      <= '0;
      duty_act_q  <= '0;
      pwm_cnt_q   <= '0;
      leds_q      <= '0;
      read_data_q <= '0;
    end else begin
      data_q      <= data_d;
      duty_q      <= duty_d;
      duty_act_q  <= duty_act_d;
      pwm_cnt_q   <= pwm_cnt_d;
      leds_q      <= leds_d;
      read_data_q <= read_data_d;
    end
  end

  assign oLeds         = leds_q;
  assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_leds_pwm_out.sv
// Directed bench for leds_pwm_out: register table plus PWM, blink, collision and reset sequences.
module tb_leds_pwm_out;

  logic        clk;
  logic        rst_n;
  logic [31:0] leds;
  int          tb_cyc;
  int          n_vec;
  int          n_bad;

  leds_pwm_out_if bus ();

  leds_pwm_out dut (
    .iClk     (clk),
    .iReset_n (rst_n),
    .bus      (bus),
    .oLeds    (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count: equals the free-running PWM counter after each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

`ifdef LEDS_BLINK_EN
  localparam logic [31:0] BlinkRb = 32'h0000_0005;
  localparam bit          BlinkOn = 1'b1;
`else
  localparam logic [31:0] BlinkRb = 32'h0000_0000;
  localparam bit          BlinkOn = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chip_select_n = 1'b0;
    bus.write_n       = 1'b0;
    bus.address       = a;
    bus.write_data    = d;
    @(posedge clk);
    #1;
    bus.chip_select_n = 1'b1;
    bus.write_n       = 1'b1;
  endtask

  // snap is the PWM count seen by the read (value before the sampling edge).
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output int snap);
    @(negedge clk);
    bus.chip_select_n = 1'b0;
    bus.read_n        = 1'b0;
    bus.address       = a;
    @(posedge clk);
    snap = tb_cyc;
    #1;
    bus.chip_select_n = 1'b1;
    bus.read_n        = 1'b1;
    d = bus.read_data;
  endtask

  task automatic wait_pwm(input int target);
    bit hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(posedge clk);
      #1;
      if ((tb_cyc & 255) == target) hit = 1'b1;
    end
    if (!hit) check("wait_pwm_timeout", 32'd0, 32'd1);
  endtask

  vec_t        tbl[13];
  logic [31:0] rd;
  int          snap;
  int          lit, misal, prev;
  logic [31:0] exp_l;

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 32'h0000_0011, 32'h0};
    tbl[1]  = '{1'b0, 2'd0, 32'h0,         32'h0000_0011};
    tbl[2]  = '{1'b1, 2'd1, 32'h0000_01FF, 32'h0};
    tbl[3]  = '{1'b0, 2'd1, 32'h0,         32'h0000_00FF};
    tbl[4]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0};
    tbl[5]  = '{1'b0, 2'd0, 32'h0,         32'hFFFF_FFFF};
    tbl[6]  = '{1'b1, 2'd3, 32'h0000_1234, 32'h0};
    tbl[7]  = '{1'b0, 2'd0, 32'h0,         32'hFFFF_FFFF};
    tbl[8]  = '{1'b1, 2'd2, 32'hFF00_0005, 32'h0};
    tbl[9]  = '{1'b0, 2'd2, 32'h0,         BlinkRb};
    tbl[10] = '{1'b1, 2'd2, 32'h0,         32'h0};
    tbl[11] = '{1'b1, 2'd0, 32'h0000_0011, 32'h0};
    tbl[12] = '{1'b0, 2'd0, 32'h0,         32'h0000_0011};

    n_vec = 0;
    n_bad = 0;
    bus.chip_select_n = 1'b1;
    bus.write_n       = 1'b1;
    bus.read_n        = 1'b1;
    bus.address       = 2'd0;
    bus.write_data    = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_leds", leds, 32'h0);
    check("reset_rdata", bus.read_data, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    bus_read(2'd3, rd, snap);
    check("reset_status", rd, 32'h8000_0000 | (snap & 255));

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].wdata);
      else begin
        bus_read(tbl[i].addr, rd, snap);
        check($sformatf("table_%0d", i), rd, tbl[i].exp);
      end
    end

    // Same-cycle read and write of DATA returns the old value.
    @(negedge clk);
    bus.chip_select_n = 1'b0;
    bus.write_n       = 1'b0;
    bus.read_n        = 1'b0;
    bus.address       = 2'd0;
    bus.write_data    = 32'h0000_003C;
    @(posedge clk);
    #1;
    bus.chip_select_n = 1'b1;
    bus.write_n       = 1'b1;
    bus.read_n        = 1'b1;
    check("rw_collision_old", bus.read_data, 32'h0000_0011);
    bus_read(2'd0, rd, snap);
    check("rw_collision_new", rd, 32'h0000_003C);
    repeat (3) @(posedge clk);
    #1 check("rdata_hold", bus.read_data, 32'h0000_003C);

    // Full duty: steady pattern after the wrap.
    bus_write(2'd1, 32'hFF);
    bus_write(2'd0, 32'hA5);
    wait_pwm(128);
    wait_pwm(0);
    misal = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      if (leds !== 32'hA5) misal++;
    end
    check("full_duty_steady", misal, 0);

    // Quarter duty: lit for exactly the 64 counts below duty_act.
    bus_write(2'd1, 32'h40);
    bus_write(2'd0, 32'hFF);
    wait_pwm(128);
    wait_pwm(0);
    lit   = 0;
    misal = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      prev  = (tb_cyc - 1) & 255;
      exp_l = (prev < 64) ? 32'hFF : 32'h0;
      if (leds === 32'hFF) lit++;
      if (leds !== exp_l) misal++;
    end
    check("duty40_lit_count", lit, 64);
    check("duty40_alignment", misal, 0);

    // Mid-period DUTY change waits for the wrap.
    wait_pwm(100);
    bus_write(2'd1, 32'hFF);
    misal = 0;
    prev  = -1;
    for (int i = 0; i < 300 && prev != 0; i++) begin
      @(posedge clk);
      #1;
      prev = (tb_cyc - 1) & 255;
      if (prev != 0 && leds !== 32'h0) misal++;
    end
    check("midperiod_no_glitch", misal, 0);
    check("midperiod_after_wrap", leds, 32'hFF);

    bus_write(2'd1, 32'h0);
    wait_pwm(128);
    wait_pwm(0);
    misal = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      if (leds !== 32'h0) misal++;
    end
    check("duty0_always_off", misal, 0);

    // Blink with period 4, then blink off.
    bus_write(2'd1, 32'hFF);
    bus_write(2'd0, 32'h1);
    wait_pwm(128);
    wait_pwm(0);
    bus_write(2'd2, 32'h4);
    misal = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      exp_l = (!BlinkOn || (((k - 1) / 4) % 2) == 0) ? 32'h1 : 32'h0;
      if (leds !== exp_l) misal++;
    end
    check("blink4_pattern", misal, 0);
    bus_write(2'd2, 32'h0);
    misal = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (leds !== 32'h1) misal++;
    end
    check("blink_off_steady", misal, 0);
    bus_read(2'd3, rd, snap);
    check("status_phase_pwm", rd, 32'h8000_0000 | (snap & 255));

    // Asynchronous reset mid-operation.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_leds", leds, 32'h0);
    check("midreset_rdata", bus.read_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    bus_read(2'd3, rd, snap);
    check("midreset_status", rd, 32'h8000_0000 | (snap & 255));
    bus_read(2'd0, rd, snap);
    check("midreset_data", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
